// File: rtl/tone_i2s_tx.sv
// tone_i2s_tx: two-channel square-wave tone generator with a 16-bit I2S output.
// Each channel's tone frequency (Hz) goes through a shared serial restoring
// divider, which turns it into a half-period count in system clocks. A
// per-channel counter toggles a level at that rate. The signed samples are
// then serialised MSB first into I2S frames of 32 bit clocks.
module tone_i2s_tx #(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int unsigned MIN_HZ = 20,
    parameter int unsigned MAX_HZ = 20_000,
    parameter logic [15:0] AMP    = 16'h2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [25:0] freqL,
    input  logic [25:0] freqR,
    input  logic [2:0]  vol,
    output logic        busy,
    output logic        mclk,
    output logic        sck,
    output logic        lrck,
    output logic        sdin
);

    localparam logic [25:0] DIVIDEND = 26'(CLK_HZ / 2);
    localparam logic [25:0] MIN_F    = 26'(MIN_HZ);
    localparam logic [25:0] MAX_F    = 26'(MAX_HZ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DIV   = 2'd2,
        STORE = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_nx_s;
    logic        sel_r;          // 0 = left channel being serviced, 1 = right
    logic        sel_nx_s;
    logic        busy_r;

    logic [8:0]  cnt_r;
    logic [31:0] sr_r;

    logic [25:0] lat_left_r;
    logic [25:0] lat_right_r;
    logic [25:0] div_r;
    logic [25:0] rem_r;
    logic [25:0] quo_r;
    logic [4:0]  bit_cnt_r;

    logic [25:0] half_left_r;
    logic [25:0] half_right_r;
    logic [25:0] tone_cnt_left_r;
    logic [25:0] tone_cnt_right_r;
    logic        level_left_r;
    logic        level_right_r;

    logic [25:0] sel_freq_s;
    logic        in_range_s;
    logic [26:0] trial_s;
    logic [25:0] rem_nx_s;
    logic        clear_left_s;
    logic        clear_right_s;
    logic [15:0] mag_s;
    logic [15:0] sample_left_s;
    logic [15:0] sample_right_s;

    // Frequency of the channel being serviced and whether it is audible
    always_comb begin
        sel_freq_s = 26'd0;
        in_range_s = 1'b0;
        if (sel_r) begin
            sel_freq_s = freqR;
        end else begin
            sel_freq_s = freqL;
        end
        in_range_s = (sel_freq_s >= MIN_F) && (sel_freq_s <= MAX_F);
    end

    // One restoring-division step: trial subtract of the divisor from the shifted remainder
    always_comb begin
        trial_s  = {rem_r, quo_r[25]} - {1'b0, div_r};
        rem_nx_s = 26'd0;
        if (trial_s[26]) begin
            rem_nx_s = {rem_r[24:0], quo_r[25]};
        end else begin
            rem_nx_s = trial_s[25:0];
        end
    end

    // Divider FSM next-state logic; the left channel wins when both have changed
    always_comb begin
        state_nx_s = state_r;
        sel_nx_s   = sel_r;
        case (state_r)
            IDLE: begin
                if (freqL != lat_left_r) begin
                    state_nx_s = LOAD;
                    sel_nx_s   = 1'b0;
                end else if (freqR != lat_right_r) begin
                    state_nx_s = LOAD;
                    sel_nx_s   = 1'b1;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            LOAD: begin
                if (in_range_s) begin
                    state_nx_s = DIV;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            DIV: begin
                if (bit_cnt_r == 5'd25) begin
                    state_nx_s = STORE;
                end else begin
                    state_nx_s = DIV;
                end
            end
            STORE:   state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // FSM state register; busy is registered from the next state so it tracks state_r exactly
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            sel_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            sel_r   <= sel_nx_s;
            busy_r  <= (state_nx_s != IDLE);
        end
    end

    // Divider datapath: latch the frequency, shift the quotient in one bit per cycle, store the half-period
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_left_r   <= 26'd0;
            lat_right_r  <= 26'd0;
            div_r        <= 26'd0;
            rem_r        <= 26'd0;
            quo_r        <= 26'd0;
            bit_cnt_r    <= 5'd0;
            half_left_r  <= 26'd0;
            half_right_r <= 26'd0;
        end else begin
            case (state_r)
                LOAD: begin
                    if (sel_r) begin
                        lat_right_r <= freqR;
                        if (!in_range_s) begin
                            half_right_r <= 26'd0;
                        end
                    end else begin
                        lat_left_r <= freqL;
                        if (!in_range_s) begin
                            half_left_r <= 26'd0;
                        end
                    end
                    div_r     <= sel_freq_s;
                    rem_r     <= 26'd0;
                    quo_r     <= DIVIDEND;
                    bit_cnt_r <= 5'd0;
                end
                DIV: begin
                    rem_r     <= rem_nx_s;
                    quo_r     <= {quo_r[24:0], ~trial_s[26]};
                    bit_cnt_r <= bit_cnt_r + 5'd1;
                end
                STORE: begin
                    if (sel_r) begin
                        half_right_r <= quo_r;
                    end else begin
                        half_left_r <= quo_r;
                    end
                end
                default: begin
                    bit_cnt_r <= bit_cnt_r;
                end
            endcase
        end
    end

    // A channel restarts its tone phase whenever its half-period is rewritten
    always_comb begin
        clear_left_s  = 1'b0;
        clear_right_s = 1'b0;
        if ((state_r == STORE) || ((state_r == LOAD) && !in_range_s)) begin
            clear_left_s  = ~sel_r;
            clear_right_s = sel_r;
        end else begin
            clear_left_s  = 1'b0;
            clear_right_s = 1'b0;
        end
    end

    // Left tone counter: toggle the level every half_left_r clocks
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tone_cnt_left_r <= 26'd0;
            level_left_r    <= 1'b0;
        end else if (clear_left_s || (half_left_r == 26'd0)) begin
            tone_cnt_left_r <= 26'd0;
            level_left_r    <= 1'b0;
        end else if (tone_cnt_left_r == (half_left_r - 26'd1)) begin
            tone_cnt_left_r <= 26'd0;
            level_left_r    <= ~level_left_r;
        end else begin
            tone_cnt_left_r <= tone_cnt_left_r + 26'd1;
        end
    end

    // Right tone counter: toggle the level every half_right_r clocks
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tone_cnt_right_r <= 26'd0;
            level_right_r    <= 1'b0;
        end else if (clear_right_s || (half_right_r == 26'd0)) begin
            tone_cnt_right_r <= 26'd0;
            level_right_r    <= 1'b0;
        end else if (tone_cnt_right_r == (half_right_r - 26'd1)) begin
            tone_cnt_right_r <= 26'd0;
            level_right_r    <= ~level_right_r;
        end else begin
            tone_cnt_right_r <= tone_cnt_right_r + 26'd1;
        end
    end

    // Signed square-wave samples, scaled by volume; a silent channel outputs zero
    always_comb begin
        mag_s          = AMP >> (3'd7 - vol);
        sample_left_s  = 16'd0;
        sample_right_s = 16'd0;
        if (half_left_r == 26'd0) begin
            sample_left_s = 16'd0;
        end else if (level_left_r) begin
            sample_left_s = mag_s;
        end else begin
            sample_left_s = 16'd0 - mag_s;
        end
        if (half_right_r == 26'd0) begin
            sample_right_s = 16'd0;
        end else if (level_right_r) begin
            sample_right_s = mag_s;
        end else begin
            sample_right_s = 16'd0 - mag_s;
        end
    end

    // Free-running frame counter; the I2S clocks are taken directly from its bits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= 9'd0;
        end else begin
            cnt_r <= cnt_r + 9'd1;
        end
    end

    // Serialiser: load both samples in slot 1, otherwise shift once per bit clock
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_r <= 32'd0;
        end else if (cnt_r[3:0] == 4'd0) begin
            if (cnt_r[8:4] == 5'd1) begin
                sr_r <= {sample_left_s, sample_right_s};
            end else begin
                sr_r <= {sr_r[30:0], 1'b0};
            end
        end else begin
            sr_r <= sr_r;
        end
    end

    assign busy = busy_r;
    assign mclk = cnt_r[1];
    assign sck  = cnt_r[3];
    assign lrck = cnt_r[8];
    assign sdin = sr_r[31];

endmodule
